// File: rtl/goe_if.sv
// goe_if: packet, PHV, verdict, port and localbus signals between pgm, goe and the output port
interface goe_if;
  logic [133:0]  in_goe_data;
  logic          in_goe_data_wr;
  logic          in_goe_valid_wr;
  logic          in_goe_valid;
  logic          out_goe_data_alf;
  logic [1023:0] in_goe_phv;
  logic          in_goe_phv_wr;
  logic          out_goe_phv_alf;
  logic [133:0]  pktout_data;
  logic          pktout_data_wr;
  logic          pktout_data_valid_wr;
  logic          pktout_data_valid;
  logic          pktout_ready;
  logic          cfg2goe_cs;
  logic          cfg2goe_rw;
  logic [15:0]   cfg2goe_addr;
  logic [31:0]   cfg2goe_wdata;
  logic          goe2cfg_ack;
  logic [31:0]   goe2cfg_rdata;
  modport slave (
    input  in_goe_data, in_goe_data_wr, in_goe_valid_wr, in_goe_valid, in_goe_phv, in_goe_phv_wr,
           pktout_ready, cfg2goe_cs, cfg2goe_rw, cfg2goe_addr, cfg2goe_wdata,
    output out_goe_data_alf, out_goe_phv_alf, pktout_data, pktout_data_wr, pktout_data_valid_wr,
           pktout_data_valid, goe2cfg_ack, goe2cfg_rdata
  );
  modport master (
    output in_goe_data, in_goe_data_wr, in_goe_valid_wr, in_goe_valid, in_goe_phv, in_goe_phv_wr,
           pktout_ready, cfg2goe_cs, cfg2goe_rw, cfg2goe_addr, cfg2goe_wdata,
    input  out_goe_data_alf, out_goe_phv_alf, pktout_data, pktout_data_wr, pktout_data_valid_wr,
           pktout_data_valid, goe2cfg_ack, goe2cfg_rdata
  );
endinterface

// File: rtl/goe.sv
// goe: buffers packets, verdicts and PHVs, forwards or drops each packet with its output port stamped into the head word
module goe #(
  parameter string      PLATFORM = "Xilinx",
  parameter logic [7:0] LMID     = 8'd7
) (
  input logic clk,
  input logic rst_n,
  goe_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SEND, DISCARD} state_t;
  state_t state;
  logic [133:0] dmem [256];
  logic         vmem [32];
  logic [7:0]   pmem [16];
  logic [7:0]   dwp, drp, hdr;
  logic [8:0]   dcnt;
  logic [4:0]   vwp, vrp, pcnt;
  logic [5:0]   vcnt;
  logic [3:0]   pwp, prp;
  logic         dwr, vwr, pwr, vp, dpop, tail, snd, first, ovf, cs_d, clr;
  logic [133:0] dq;
  logic [31:0]  in_cnt, out_cnt, drop_cnt, rd;
  always_comb begin
    dwr  = bus.in_goe_data_wr && !dcnt[8];
    vwr  = bus.in_goe_valid_wr && !vcnt[5];
    pwr  = bus.in_goe_phv_wr && !pcnt[4];
    vp   = state == IDLE && vcnt != 0 && pcnt != 0;
    dpop = dcnt != 0 && (state == DISCARD || (state == SEND && bus.pktout_ready));
    snd  = dpop && state == SEND;
    dq   = dmem[drp];
    tail = dq[133:132] == 2'b10;
    clr  = bus.cfg2goe_cs && !cs_d && !bus.cfg2goe_rw && bus.cfg2goe_addr == 16'h5 && bus.cfg2goe_wdata[0];
    rd   = bus.cfg2goe_addr == 16'h0 ? {24'b0, LMID} :
           bus.cfg2goe_addr == 16'h1 ? in_cnt :
           bus.cfg2goe_addr == 16'h2 ? out_cnt :
           bus.cfg2goe_addr == 16'h3 ? drop_cnt :
           bus.cfg2goe_addr == 16'h4 ? {31'b0, ovf} : 32'b0;
  end
  assign bus.out_goe_data_alf = dcnt >= 9'd192 || vcnt >= 6'd28;
  assign bus.out_goe_phv_alf  = pcnt >= 5'd12;
  // Only the output-port byte of each PHV is ever consumed, so only that byte is stored.
  always_ff @(posedge clk) begin
    if (dwr) dmem[dwp] <= bus.in_goe_data;
    if (vwr) vmem[vwp] <= bus.in_goe_valid;
    if (pwr) pmem[pwp] <= bus.in_goe_phv[1023:1016];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      {dwp, drp, dcnt, vwp, vrp, vcnt, pwp, prp, pcnt} <= '0;
      {hdr, first, ovf, cs_d, in_cnt, out_cnt, drop_cnt} <= '0;
      bus.pktout_data <= '0;
      bus.pktout_data_wr <= 1'b0;
      bus.pktout_data_valid_wr <= 1'b0;
      bus.pktout_data_valid <= 1'b0;
      bus.goe2cfg_ack <= 1'b0;
      bus.goe2cfg_rdata <= '0;
    end else begin
      dwp  <= dwp + 8'(dwr);
      drp  <= drp + 8'(dpop);
      dcnt <= dcnt + 9'(dwr) - 9'(dpop);
      vwp  <= vwp + 5'(vwr);
      vrp  <= vrp + 5'(vp);
      vcnt <= vcnt + 6'(vwr) - 6'(vp);
      pwp  <= pwp + 4'(pwr);
      prp  <= prp + 4'(vp);
      pcnt <= pcnt + 5'(pwr) - 5'(vp);
      ovf  <= ovf | (bus.in_goe_data_wr & dcnt[8]) | (bus.in_goe_valid_wr & vcnt[5]) | (bus.in_goe_phv_wr & pcnt[4]);
      bus.pktout_data_wr <= snd;
      bus.pktout_data_valid_wr <= snd && tail;
      bus.pktout_data_valid <= snd && tail;
      if (snd) begin
        bus.pktout_data <= first ? {dq[133:128], hdr, dq[119:0]} : dq;
        first <= 1'b0;
      end
      if (vp) begin
        state <= vmem[vrp] ? SEND : DISCARD;
        hdr <= pmem[prp];
        first <= 1'b1;
      end else if (dpop && tail) state <= IDLE;
      in_cnt   <= clr ? 32'b0 : in_cnt + 32'(vwr);
      out_cnt  <= clr ? 32'b0 : out_cnt + 32'(snd && tail);
      drop_cnt <= clr ? 32'b0 : drop_cnt + 32'(dpop && state == DISCARD && tail);
      cs_d <= bus.cfg2goe_cs;
      bus.goe2cfg_ack <= bus.cfg2goe_cs && !cs_d;
      bus.goe2cfg_rdata <= bus.cfg2goe_cs && !cs_d && bus.cfg2goe_rw ? rd : 32'b0;
    end
  end
endmodule

// File: tb/tb_goe.sv
// tb_goe: directed, table-driven bench for goe with hand-written reset, fill and mid-packet abort sequences
module tb_goe;
  logic clk = 0, rst_n = 0, tgl = 0, rdy_e = 0;
  int total = 0, bad = 0, vt = 0, viol = 0;
  logic [133:0] q[$];
  logic [31:0] d;
  always #5 clk = ~clk;
  goe_if g();
  goe #(.PLATFORM("Xilinx"), .LMID(8'd7)) dut (.clk(clk), .rst_n(rst_n), .bus(g.slave));

  typedef struct {
    int n; logic v; logic [7:0] port; logic tgl;
    int exp_words; int exp_in; int exp_out; int exp_drop;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [133:0] act, input logic [133:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  function automatic logic [133:0] mkword(input int id, input int i, input int n);
    logic [1:0] t;
    logic [15:0] s;
    t = (i == n - 1) ? 2'b10 : (i == 0) ? 2'b01 : 2'b11;
    s = 16'(id * 256 + i) ^ 16'h1234;
    return {t, (i == n - 1) ? 4'h3 : 4'h0, 8'(id), 8'(i), {7{s}}};
  endfunction

  function automatic logic [133:0] expw(input int id, input int i, input int n, input logic [7:0] port);
    logic [133:0] w;
    w = mkword(id, i, n);
    if (i == 0) w[127:120] = port;
    return w;
  endfunction

  task automatic send_pkt(input int id, input int n, input logic v, input logic [7:0] port);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      g.in_goe_data = mkword(id, i, n);
      g.in_goe_data_wr = 1;
    end
    @(negedge clk);
    g.in_goe_data_wr = 0;
    g.in_goe_phv = {port, {127{8'hC3}}};
    g.in_goe_phv_wr = 1;
    g.in_goe_valid = v;
    g.in_goe_valid_wr = 1;
    @(negedge clk);
    g.in_goe_phv_wr = 0;
    g.in_goe_valid_wr = 0;
  endtask

  task automatic rd_reg(input logic [15:0] a, output logic [31:0] dat);
    @(negedge clk);
    g.cfg2goe_cs = 1; g.cfg2goe_rw = 1; g.cfg2goe_addr = a;
    @(negedge clk);
    chk("ack", 134'(g.goe2cfg_ack), 134'(1));
    dat = g.goe2cfg_rdata;
    g.cfg2goe_cs = 0;
    @(negedge clk);
    chk("ack_pulse", 134'(g.goe2cfg_ack), 134'(0));
  endtask

  task automatic chk_reg(input string name, input logic [15:0] a, input logic [31:0] exp);
    logic [31:0] r;
    rd_reg(a, r);
    chk(name, 134'(r), 134'(exp));
  endtask

  task automatic wr_reg(input logic [15:0] a, input logic [31:0] w);
    @(negedge clk);
    g.cfg2goe_cs = 1; g.cfg2goe_rw = 0; g.cfg2goe_addr = a; g.cfg2goe_wdata = w;
    @(negedge clk);
    g.cfg2goe_cs = 0;
    @(negedge clk);
  endtask

  task automatic wait_words(input int n);
    for (int c = 0; c < 200 && q.size() < n; c++) @(negedge clk);
    repeat (10) @(negedge clk);
  endtask

  initial begin
    g.pktout_ready = 1;
    forever @(negedge clk) g.pktout_ready = tgl ? ~g.pktout_ready : 1'b1;
  end
  always @(posedge clk) rdy_e = g.pktout_ready;
  always @(negedge clk)
    if (rst_n && g.pktout_data_wr) begin
      q.push_back(g.pktout_data);
      if (!rdy_e) viol++;
      if (g.pktout_data_valid_wr && g.pktout_data_valid && g.pktout_data[133:132] == 2'b10) vt++;
    end

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{3, 1'b1, 8'h05, 1'b0, 3, 1, 1, 0};
    vecs[1] = '{2, 1'b0, 8'h09, 1'b0, 0, 2, 1, 1};
    vecs[2] = '{1, 1'b1, 8'h0A, 1'b0, 1, 3, 2, 1};
    vecs[3] = '{4, 1'b1, 8'h3C, 1'b1, 4, 4, 3, 1};
    vecs[4] = '{6, 1'b0, 8'h11, 1'b1, 0, 5, 3, 2};
    vecs[5] = '{5, 1'b1, 8'hFF, 1'b1, 5, 6, 4, 2};
    g.in_goe_data = '0; g.in_goe_data_wr = 0; g.in_goe_valid_wr = 0; g.in_goe_valid = 0;
    g.in_goe_phv = '0; g.in_goe_phv_wr = 0;
    g.cfg2goe_cs = 0; g.cfg2goe_rw = 0; g.cfg2goe_addr = '0; g.cfg2goe_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_data_wr", 134'(g.pktout_data_wr), 134'(0));
    chk("rst_data", g.pktout_data, 134'(0));
    chk("rst_valid_wr", 134'(g.pktout_data_valid_wr), 134'(0));
    chk("rst_ack", 134'(g.goe2cfg_ack), 134'(0));
    chk("rst_rdata", 134'(g.goe2cfg_rdata), 134'(0));
    chk("rst_data_alf", 134'(g.out_goe_data_alf), 134'(0));
    chk("rst_phv_alf", 134'(g.out_goe_phv_alf), 134'(0));
    rst_n = 1;
    chk_reg("lmid", 16'h0, 32'h7);
    chk_reg("status0", 16'h4, 32'h0);
    for (int k = 0; k < 6; k++) begin
      q.delete(); vt = 0; viol = 0; tgl = vecs[k].tgl;
      send_pkt(k + 1, vecs[k].n, vecs[k].v, vecs[k].port);
      wait_words(vecs[k].exp_words);
      tgl = 0;
      chk($sformatf("v%0d_words", k), 134'(q.size()), 134'(vecs[k].exp_words));
      for (int i = 0; i < vecs[k].exp_words && i < q.size(); i++)
        chk($sformatf("v%0d_word%0d", k, i), q[i], expw(k + 1, i, vecs[k].n, vecs[k].port));
      chk($sformatf("v%0d_valid_tail", k), 134'(vt), 134'(vecs[k].v));
      chk($sformatf("v%0d_ready_viol", k), 134'(viol), 134'(0));
      chk_reg($sformatf("v%0d_in_cnt", k), 16'h1, 32'(vecs[k].exp_in));
      chk_reg($sformatf("v%0d_out_cnt", k), 16'h2, 32'(vecs[k].exp_out));
      chk_reg($sformatf("v%0d_drop_cnt", k), 16'h3, 32'(vecs[k].exp_drop));
    end
    wr_reg(16'h5, 32'h0);
    chk_reg("noclr_out_cnt", 16'h2, 32'd4);
    wr_reg(16'h6, 32'h1);
    chk_reg("wr6_in_cnt", 16'h1, 32'd6);
    wr_reg(16'h5, 32'h1);
    chk_reg("clr_in_cnt", 16'h1, 32'h0);
    chk_reg("clr_out_cnt", 16'h2, 32'h0);
    chk_reg("clr_drop_cnt", 16'h3, 32'h0);
    chk_reg("unmapped", 16'h10, 32'h0);
    for (int i = 1; i <= 257; i++) begin
      @(negedge clk);
      if (i == 192) chk("alf_191", 134'(g.out_goe_data_alf), 134'(0));
      if (i == 193) chk("alf_192", 134'(g.out_goe_data_alf), 134'(1));
      g.in_goe_data = mkword(100, 1, 3);
      g.in_goe_data_wr = 1;
    end
    @(negedge clk);
    g.in_goe_data_wr = 0;
    chk_reg("ovf", 16'h4, 32'h1);
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (i == 12) chk("phv_alf_11", 134'(g.out_goe_phv_alf), 134'(0));
      g.in_goe_phv = {8'h01, {127{8'h5A}}};
      g.in_goe_phv_wr = 1;
    end
    @(negedge clk);
    g.in_goe_phv_wr = 0;
    chk("phv_alf_12", 134'(g.out_goe_phv_alf), 134'(1));
    #1 rst_n = 0;
    #1;
    chk("rst2_data_alf", 134'(g.out_goe_data_alf), 134'(0));
    chk("rst2_phv_alf", 134'(g.out_goe_phv_alf), 134'(0));
    @(negedge clk);
    rst_n = 1;
    chk_reg("rst2_status", 16'h4, 32'h0);
    q.delete();
    send_pkt(50, 5, 1'b1, 8'h42);
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      #1;
      if (q.size() >= 2) break;
    end
    chk("v6_pre_words", 134'(q.size() >= 2), 134'(1));
    rst_n = 0;
    #1;
    chk("v6_data_wr", 134'(g.pktout_data_wr), 134'(0));
    chk("v6_data", g.pktout_data, 134'(0));
    chk("v6_valid_wr", 134'(g.pktout_data_valid_wr), 134'(0));
    chk("v6_valid", 134'(g.pktout_data_valid), 134'(0));
    repeat (2) @(negedge clk);
    rst_n = 1;
    q.delete(); vt = 0; viol = 0;
    chk_reg("v6_in_cnt0", 16'h1, 32'h0);
    chk_reg("v6_out_cnt0", 16'h2, 32'h0);
    send_pkt(60, 5, 1'b1, 8'h77);
    wait_words(5);
    chk("v6_words", 134'(q.size()), 134'(5));
    for (int i = 0; i < 5 && i < q.size(); i++)
      chk($sformatf("v6_word%0d", i), q[i], expw(60, i, 5, 8'h77));
    chk("v6_valid_tail", 134'(vt), 134'(1));
    chk_reg("v6_out_cnt", 16'h2, 32'h1);
    chk_reg("v6_in_cnt", 16'h1, 32'h1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/goe.md
GOE -- requirements
Module: goe

Interface
REQ-001 Parameter PLATFORM, default "Xilinx": target vendor string, no functional effect.
REQ-002 Parameter LMID, default 8'd7: own module ID, returned at localbus address 0x0000.
REQ-003 clk  input  1  single clock, all logic on posedge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_goe_data / in_goe_data_wr  input  134/1  packet word from pgm; [133:132] 01=head, 11=body, 10=tail; [131:128] invalid bytes in tail; [127:0] payload.
REQ-006 in_goe_valid_wr / in_goe_valid  input  1/1  per-packet verdict pulse, on or after tail; 1=forward, 0=drop.
REQ-007 out_goe_data_alf  output  1  data almost-full to pgm.
REQ-008 in_goe_phv / in_goe_phv_wr  input  1024/1  one PHV per packet; [1023:1016]=output port.
REQ-009 out_goe_phv_alf  output  1  PHV almost-full to pgm.
REQ-010 pktout_data / pktout_data_wr  output  134/1  packet word to port.
REQ-011 pktout_data_valid_wr / pktout_data_valid  output  1/1  per-packet verdict to port, always valid=1.
REQ-012 pktout_ready  input  1  port may accept a word this cycle.
REQ-013 cfg2goe_cs, cfg2goe_rw (0 write, 1 read), cfg2goe_addr[15:0], cfg2goe_wdata[31:0]  input; goe2cfg_ack, goe2cfg_rdata[31:0]  output  localbus.

Function
REQ-014 Data FIFO 256x134; verdict FIFO 32x1; PHV FIFO 16x1024; writes unconditional on the respective _wr strobes.
REQ-015 out_goe_data_alf SHALL be 1 when data FIFO usedw >= 192 or verdict FIFO usedw >= 28.
REQ-016 out_goe_phv_alf SHALL be 1 when PHV FIFO usedw >= 12.
REQ-017 Write to a full FIFO SHALL be dropped and set sticky bit ovf (status bit 0), cleared only by reset.
REQ-018 FSM states IDLE, SEND, DISCARD; reset state IDLE.
REQ-019 IDLE -> SEND when verdict and PHV FIFOs both non-empty and verdict head=1; -> DISCARD when both non-empty and verdict head=0; both pops occur on the transition.
REQ-020 SEND: each cycle pktout_ready=1 and data FIFO non-empty, pop one word and present it registered next cycle with pktout_data_wr=1; no pop when pktout_ready=0.
REQ-021 SEND head word: bits [127:120] SHALL be replaced by popped PHV [1023:1016]; all other words unmodified.
REQ-022 SEND on popping the tail word: next cycle assert pktout_data_wr with tail plus pktout_data_valid_wr=1, pktout_data_valid=1; FSM returns to IDLE; pkt_out_cnt increments.
REQ-023 DISCARD: pop one word per cycle when non-empty regardless of pktout_ready, nothing output; on tail return to IDLE; pkt_drop_cnt increments.
REQ-024 Word after an unexpected head (head seen while not expecting) SHALL be treated as continuation; no resynchronisation.
REQ-025 pkt_in_cnt increments on each in_goe_valid_wr accepted into verdict FIFO.
REQ-026 Counters 32-bit, wrap 0xFFFFFFFF -> 0, no saturation.
REQ-027 Localbus: read addresses 0x0000 LMID (zero-extended), 0x0001 pkt_in_cnt, 0x0002 pkt_out_cnt, 0x0003 pkt_drop_cnt, 0x0004 status; unmapped read returns 0.
REQ-028 Write to 0x0005 with wdata[0]=1 SHALL clear all three counters in the same cycle; other writes ignored; counter increment coinciding with clear yields 0.
REQ-029 goe2cfg_ack SHALL pulse one cycle, one cycle after cs rises; rdata valid with ack; cs must drop before next access.
REQ-030 Latency: FIFO pop to pktout_data_wr exactly 1 cycle; input write to earliest output 3 cycles.

Reset
REQ-031 On rst_n=0 all outputs SHALL be 0, FIFOs emptied, counters and ovf 0, FSM IDLE, immediately and asynchronously.
REQ-032 Reset asserted mid-packet SHALL abort the packet with no tail or verdict emitted; after release first output is the next full packet.

Verification
V1 3-word packet, verdict 1, PHV[1023:1016]=0x05, ready=1 -> 3 words out, head[127:120]=0x05, valid_wr with tail, pkt_out_cnt=1.
V2 2-word packet verdict 0 then 1-word packet verdict 1 -> only second packet out, pkt_drop_cnt=1, pkt_out_cnt=1.
V3 4-word packet, pktout_ready toggled 1,0,1,0... -> exactly 4 words, order intact, no word when ready=0 popped.
V4 Write 200 words, no verdict -> out_goe_data_alf=1 from usedw 192; write 57 more -> ovf=1 at status 0x0004.
V5 Read 0x0000 -> ack one cycle after cs, rdata=0x00000007; write 0x0005=1 -> counters read 0.
V6 rst_n low at word 2 of a 5-word packet -> all outputs 0, counters 0; next packet emitted intact.
